// File: rtl/axis2uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : axis2uart_tx
// Description : AXI-Stream byte sink feeding a UART core register port.
//               Bytes are buffered in a FIFO; LCR is programmed once after
//               reset, then LSR is polled per byte and THR is written only
//               when the transmitter-empty bit (LSR[6]) is set.
//               Optional macro AXIS2UART_TX_CRLF_EN: a popped LF (8'h0A) is
//               sent as CR (8'h0D) followed by LF, each with its own poll.
// Revision    : 1.0 - initial release
// ============================================================================
module axis2uart_tx #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         RD_WAIT    = 4,
  parameter logic [7:0] INIT_LCR   = 8'h03
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    term_in_tdata,
  input  logic                          term_in_tvalid,
  output logic                          term_in_tready,
  output logic                          i_tx_en,
  output logic [2:0]                    waddr,
  output logic [7:0]                    wdata,
  output logic                          i_rx_en,
  output logic [2:0]                    raddr,
  input  logic [7:0]                    rdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int         c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int         c_LVL_W    = c_PTR_W + 1;
  localparam int         c_CNT_W    = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [2:0] c_ADDR_THR = 3'd0;
  localparam logic [2:0] c_ADDR_LCR = 3'd3;
  localparam logic [2:0] c_ADDR_LSR = 3'd5;
  localparam int         c_TEMT_BIT = 6;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_POLL_RD   = 3'd2,
    S_POLL_WAIT = 3'd3,
    S_POLL_CHK  = 3'd4,
    S_TX_WR     = 3'd5,
    S_TX_GAP    = 3'd6
  } state_t;

  // FIFO
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_count;
  logic [c_LVL_W-1:0] w_count_nxt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_pop_ok;
  logic [7:0]         w_head;

  // FSM
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_init_done;
  logic               w_init_done_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [7:0]         r_status;
  logic [7:0]         w_status_nxt;
  logic [7:0]         r_tx_byte;
  logic [7:0]         w_tx_byte_nxt;
  logic               r_busy;
  logic               w_tx_en;
  logic               w_rx_en;
  logic [2:0]         w_waddr;
  logic [7:0]         w_wdata;
  logic [2:0]         w_raddr;
  logic               w_unused_status;

`ifdef AXIS2UART_TX_CRLF_EN
  localparam logic [7:0] c_LF = 8'h0A;
  localparam logic [7:0] c_CR = 8'h0D;
  logic r_lf_pending;
  logic w_lf_pending_nxt;
`endif

  assign w_full          = (r_count == c_LVL_W'(FIFO_DEPTH));
  assign w_empty         = (r_count == '0);
  assign term_in_tready  = !w_full && r_init_done;
  assign w_push          = term_in_tvalid && term_in_tready;
  assign w_pop_ok        = w_pop && !w_empty;
  assign w_head          = r_mem[r_rd_ptr];
  assign fifo_level      = r_count;
  assign busy            = r_busy;
  // Only the TEMT bit drives decisions; the rest of the status is kept for visibility
  assign w_unused_status = ^{r_status[7], r_status[5:0]};

  // Byte storage; validity is tracked by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= term_in_tdata;
    end
  end

  // Occupancy: simultaneous push and pop leaves the level unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop_ok) begin
      w_count_nxt = r_count + c_LVL_W'(1);
    end else if (!w_push && w_pop_ok) begin
      w_count_nxt = r_count - c_LVL_W'(1);
    end
  end

  // FIFO pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Next-state, register-port outputs and datapath updates
  always_comb begin
    w_state_nxt     = r_state;
    w_init_done_nxt = r_init_done;
    w_cnt_nxt       = r_cnt;
    w_status_nxt    = r_status;
    w_tx_byte_nxt   = r_tx_byte;
    w_pop           = 1'b0;
    w_tx_en         = 1'b0;
    w_rx_en         = 1'b0;
    w_waddr         = waddr;
    w_wdata         = wdata;
    w_raddr         = raddr;
`ifdef AXIS2UART_TX_CRLF_EN
    w_lf_pending_nxt = r_lf_pending;
`endif
    case (r_state)
      S_INIT: begin
        w_tx_en         = 1'b1;
        w_waddr         = c_ADDR_LCR;
        w_wdata         = INIT_LCR;
        w_init_done_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        w_rx_en     = 1'b1;
        w_raddr     = c_ADDR_LSR;
        w_cnt_nxt   = c_CNT_W'(RD_WAIT);
        w_state_nxt = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (r_cnt == '0) begin
          w_status_nxt = rdata;
          w_state_nxt  = S_POLL_CHK;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
      S_POLL_CHK: begin
        if (r_status[c_TEMT_BIT]) begin
`ifdef AXIS2UART_TX_CRLF_EN
          // An LF stays at the head until its preceding CR has gone out
          if (!r_lf_pending && (w_head == c_LF)) begin
            w_tx_byte_nxt    = c_CR;
            w_lf_pending_nxt = 1'b1;
          end else begin
            w_pop            = 1'b1;
            w_tx_byte_nxt    = w_head;
            w_lf_pending_nxt = 1'b0;
          end
`else
          w_pop         = 1'b1;
          w_tx_byte_nxt = w_head;
`endif
          w_state_nxt = S_TX_WR;
        end else begin
          w_state_nxt = S_POLL_RD;
        end
      end
      S_TX_WR: begin
        w_tx_en     = 1'b1;
        w_waddr     = c_ADDR_THR;
        w_wdata     = r_tx_byte;
        w_state_nxt = S_TX_GAP;
      end
      S_TX_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // State, datapath and registered register-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_init_done <= 1'b0;
      r_cnt       <= '0;
      r_status    <= '0;
      r_tx_byte   <= '0;
      r_busy      <= 1'b0;
      i_tx_en     <= 1'b0;
      i_rx_en     <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      raddr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= w_init_done_nxt;
      r_cnt       <= w_cnt_nxt;
      r_status    <= w_status_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_busy      <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
      i_tx_en     <= w_tx_en;
      i_rx_en     <= w_rx_en;
      waddr       <= w_waddr;
      wdata       <= w_wdata;
      raddr       <= w_raddr;
    end
  end

`ifdef AXIS2UART_TX_CRLF_EN
  // Remembers that a CR was sent for the LF still at the FIFO head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lf_pending <= 1'b0;
    end else begin
      r_lf_pending <= w_lf_pending_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis2uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis2uart_tx
// Description : Self-checking bench for axis2uart_tx with a queue-based
//               reference model of the transmitted byte sequence and a
//               simple LSR responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis2uart_tx;

  localparam int         FIFO_DEPTH = 16;
  localparam int         RD_WAIT    = 4;
  localparam logic [7:0] INIT_LCR   = 8'h03;
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       term_in_tdata = 8'h00;
  logic             term_in_tvalid = 1'b0;
  logic             term_in_tready;
  logic             i_tx_en;
  logic [2:0]       waddr;
  logic [7:0]       wdata;
  logic             i_rx_en;
  logic [2:0]       raddr;
  logic [7:0]       rdata = 8'h00;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  axis2uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RD_WAIT    (RD_WAIT),
    .INIT_LCR   (INIT_LCR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .term_in_tdata  (term_in_tdata),
    .term_in_tvalid (term_in_tvalid),
    .term_in_tready (term_in_tready),
    .i_tx_en        (i_tx_en),
    .waddr          (waddr),
    .wdata          (wdata),
    .i_rx_en        (i_rx_en),
    .raddr          (raddr),
    .rdata          (rdata),
    .busy           (busy),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model / responder state
  logic [7:0] exp_q[$];
  logic [7:0] lsr_q[$];
  logic [7:0] lsr_default = 8'h60;
  logic [7:0] last_poll = 8'h00;
  int model_cnt = 0;
  int lcr_cnt = 0;
  int thr_cnt = 0;
  int poll_cnt = 0;
  int polls_since_thr = 0;
  int last_acc_edge = 0;
  int last_thr_edge = 0;
  int overlap_cnt = 0;
  int tready_drop_cnt = 0;
  bit track_tready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected UART byte sequence for an accepted stream byte
  function automatic void model_accept(input logic [7:0] b);
`ifdef AXIS2UART_TX_CRLF_EN
    if (b == 8'h0A) begin
      exp_q.push_back(8'h0D);
      model_cnt++;
    end
`endif
    exp_q.push_back(b);
    model_cnt++;
  endfunction

  // Observe handshakes and register-port strobes; answer LSR reads
  always @(negedge clk) begin
    if (!rst) begin
      if (term_in_tvalid && term_in_tready) begin
        model_accept(term_in_tdata);
        last_acc_edge = cyc + 1;
      end
      if (track_tready && !term_in_tready) tready_drop_cnt++;
      if (i_tx_en && i_rx_en) overlap_cnt++;
      if (i_rx_en) begin
        check("poll_raddr", 32'(raddr), 32'd5);
        poll_cnt++;
        polls_since_thr++;
        if (lsr_q.size() > 0) last_poll = lsr_q.pop_front();
        else last_poll = lsr_default;
        rdata = last_poll;
      end
      if (i_tx_en) begin
        if (waddr == 3'd3) begin
          lcr_cnt++;
          check("lcr_data", 32'(wdata), 32'(INIT_LCR));
        end else begin
          check("thr_addr", 32'(waddr), 32'd0);
          check("thr_temt_seen", 32'(last_poll[6]), 32'd1);
          check("thr_own_poll", 32'(polls_since_thr >= 1), 32'd1);
          polls_since_thr = 0;
          thr_cnt++;
          last_thr_edge = cyc;
          check("thr_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("thr_data", 32'(wdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte; returns just after the accepting edge with tvalid low
  task automatic send_byte(input logic [7:0] b, input int budget);
    bit ok;
    ok = 1'b0;
    term_in_tdata  = b;
    term_in_tvalid = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (term_in_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    term_in_tvalid = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_level == '0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 32'(done), 32'd1);
    tick(1);
  endtask

  int thr0, poll0, model0, nb, nz;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_outputs",
          32'({i_tx_en, i_rx_en, waddr, wdata, raddr, busy, fifo_level, term_in_tready}), 32'd0);

    // Release: single LCR write, then tready high
    rst = 1'b0;
    @(negedge clk);
    check("tready_pre_init", 32'(term_in_tready), 32'd0);
    tick(4);
    check("lcr_once", 32'(lcr_cnt), 32'd1);
    check("tready_post_init", 32'(term_in_tready), 32'd1);

    // Single byte with TEMT already set
    lsr_default = 8'h60;
    thr0 = thr_cnt; poll0 = poll_cnt;
    send_byte(8'h41, 10);
    wait_drain(100);
    check("single_thr_cnt", 32'(thr_cnt - thr0), 32'd1);
    check("single_polls", 32'(poll_cnt - poll0), 32'd1);
    check("single_latency", 32'(last_thr_edge - last_acc_edge), 32'(RD_WAIT + 5));

    // Three not-ready polls before TEMT
    lsr_q.push_back(8'h00); lsr_q.push_back(8'h00); lsr_q.push_back(8'h00);
    lsr_default = 8'h40;
    thr0 = thr_cnt; poll0 = poll_cnt;
    tready_drop_cnt = 0;
    track_tready = 1'b1;
    send_byte(8'($urandom), 10);
    wait_drain(200);
    track_tready = 1'b0;
    check("retry_polls", 32'(poll_cnt - poll0), 32'd4);
    check("retry_thr_cnt", 32'(thr_cnt - thr0), 32'd1);
    check("retry_tready_held", 32'(tready_drop_cnt), 32'd0);

    // Burst of 20 with TEMT low: FIFO fills to 16 and backpressures
    lsr_default = 8'h00;
    thr0 = thr_cnt; model0 = model_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 20);
    term_in_tdata  = 8'd16;
    term_in_tvalid = 1'b1;
    tick(3);
    check("burst_tready_full", 32'(term_in_tready), 32'd0);
    check("burst_level_full", 32'(fifo_level), 32'd16);
    check("burst_nothing_sent", 32'(thr_cnt - thr0), 32'd0);
    lsr_default = 8'h40;
    for (int i = 16; i < 20; i++) send_byte(8'(i), 400);
    wait_drain(1500);
    check("burst_thr_cnt", 32'(thr_cnt - thr0), 32'(model_cnt - model0));
    check("burst_level_empty", 32'(fifo_level), 32'd0);

    // Randomized bytes, gaps and LSR responses
    thr0 = thr_cnt; model0 = model_cnt;
    for (int it = 0; it < 8; it++) begin
      nz = $urandom_range(0, 2);
      for (int k = 0; k < nz; k++) lsr_q.push_back(8'($urandom) & 8'hBF);
      lsr_default = 8'($urandom) | 8'h40;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) send_byte(8'($urandom), 200);
      tick($urandom_range(0, 12));
    end
    wait_drain(1000);
    check("rand_thr_cnt", 32'(thr_cnt - thr0), 32'(model_cnt - model0));
    check("rand_lsr_consumed", 32'(lsr_q.size()), 32'd0);

    // Reset during POLL_WAIT with 5 bytes queued
    lsr_default = 8'h00;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 20);
    begin : wait_poll
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (i_rx_en) begin
          seen = 1'b1;
          break;
        end
      end
      check("mid_poll_seen", 32'(seen), 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs",
          32'({i_tx_en, i_rx_en, waddr, wdata, raddr, busy, term_in_tready}), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    exp_q.delete();
    lsr_q.delete();
    lcr_cnt = 0;
    thr0 = thr_cnt;
    tick(2);
    rst = 1'b0;
    lsr_default = 8'h60;
    tick(60);
    check("mid_rst_lcr_again", 32'(lcr_cnt), 32'd1);
    check("mid_rst_no_stale", 32'(thr_cnt - thr0), 32'd0);
    check("mid_rst_level_after", 32'(fifo_level), 32'd0);

    // Line feed: expanded to CR,LF only when the option is built in
    lsr_default = 8'h40;
    thr0 = thr_cnt; model0 = model_cnt;
    send_byte(8'h0A, 10);
    wait_drain(200);
    check("lf_thr_cnt", 32'(thr_cnt - thr0), 32'(model_cnt - model0));

    check("no_strobe_overlap", 32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
